// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-word field offsets, special register
// numbers and RegDst encodings used by the ID/EX stage.
package mips_pkg;

  localparam int CTRL_W = 22;

  // LSB-anchored field offsets. Twenty-two bits leave room for only the low
  // two PCSrc bits, so PCSrc occupies bits 21:20.
  localparam int CTRL_ALUFUN   = 0;
  localparam int CTRL_JUMP     = 6;
  localparam int CTRL_SIGN     = 7;
  localparam int CTRL_LUOP     = 8;
  localparam int CTRL_EXTOP    = 9;
  localparam int CTRL_MEMREAD  = 10;
  localparam int CTRL_MEMWRITE = 11;
  localparam int CTRL_BRANCH   = 12;
  localparam int CTRL_ALUSRC2  = 13;
  localparam int CTRL_ALUSRC1  = 14;
  localparam int CTRL_REGWRITE = 15;
  localparam int CTRL_MEMTOREG = 16;
  localparam int CTRL_REGDST   = 18;
  localparam int CTRL_PCSRC    = 20;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_XP = 5'd26;

  typedef enum logic [1:0] {
    REGDST_RD = 2'd0,
    REGDST_RT = 2'd1,
    REGDST_RA = 2'd2,
    REGDST_XP = 2'd3
  } regdst_e;

  function automatic logic [4:0] resolve_wreg(input regdst_e sel,
                                              input logic [4:0] rt,
                                              input logic [4:0] rd);
    case (sel)
      REGDST_RD: resolve_wreg = rd;
      REGDST_RT: resolve_wreg = rt;
      REGDST_RA: resolve_wreg = REG_RA;
      default:   resolve_wreg = REG_XP;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that needs the result of a
// load currently sitting in EX.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_wreg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  // Loads to $0 never produce a value worth waiting for.
  assign load_use = ex_valid & ex_memread & (ex_wreg != 5'd0) &
                    ((ex_wreg == id_rs) | (id_uses_rt & (ex_wreg == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, write-register
// resolution and a saturating count of inserted load-use bubbles.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = mips_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic              hold,
  input  logic              flush,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_shamt,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_wreg,
  output logic              ex_valid,
  output logic              stall_id,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic       load_use;
  logic [4:0] id_wreg;

  hazard_detect u_hazard (
    .ex_valid  (ex_valid),
    .ex_memread(ex_ctrl[CTRL_MEMREAD]),
    .ex_wreg   (ex_wreg),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_uses_rt(id_uses_rt),
    .load_use  (load_use)
  );

  assign id_wreg  = resolve_wreg(regdst_e'(id_ctrl[CTRL_REGDST +: 2]), id_rt, id_rd);

  // A flush already kills the dependent instruction, so it needs no stall.
  assign stall_id = hold | (load_use & ~flush);

  // Priority: reset, hold, flush bubble, load-use bubble, normal capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl     <= '0;
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_shamt    <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wreg     <= '0;
      ex_valid    <= 1'b0;
      bubble_cnt  <= '0;
    end else if (hold) begin
      ex_valid    <= ex_valid;
    end else if (flush || load_use) begin
      ex_ctrl     <= '0;
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_shamt    <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_wreg     <= '0;
      ex_valid    <= 1'b0;
      if (!flush && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      ex_ctrl     <= id_ctrl;
      ex_pc_plus4 <= id_pc_plus4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_shamt    <= id_shamt;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_wreg     <= id_wreg;
      ex_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stalls, flush/hold priority,
// write-register resolution and bubble counter saturation.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 22;
  localparam int CNT_W  = 16;

  // Hand-packed control words (bit 10 MemRead, 11 MemWrite, 13 ALUSrc2,
  // 15 RegWrite, 17:16 MemtoReg, 19:18 RegDst).
  localparam logic [CTRL_W-1:0] C_LW   = 22'h058400;
  localparam logic [CTRL_W-1:0] C_ADD  = 22'h008001;
  localparam logic [CTRL_W-1:0] C_SW   = 22'h002800;
  localparam logic [CTRL_W-1:0] C_JAL  = 22'h088000;
  localparam logic [CTRL_W-1:0] C_XP   = 22'h0C8000;

  logic              clk = 1'b0;
  logic              reset;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]        id_shamt, id_rs, id_rt, id_rd;
  logic              id_uses_rt, hold, flush;

  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]        ex_shamt, ex_rs, ex_rt, ex_wreg;
  logic              ex_valid, stall_id;
  logic [CNT_W-1:0]  bubble_cnt;

  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_pc_plus4, s_rs_data, s_rt_data, s_imm;
  logic [4:0]        s_shamt, s_rs, s_rt, s_wreg;
  logic              s_valid, s_stall;
  logic [1:0]        s_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .hold(hold), .flush(flush),
    .ex_ctrl(ex_ctrl), .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_shamt(ex_shamt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_valid(ex_valid),
    .stall_id(stall_id), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, used to reach saturation.
  id_ex_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_pc_plus4(id_pc_plus4),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .hold(hold), .flush(flush),
    .ex_ctrl(s_ctrl), .ex_pc_plus4(s_pc_plus4), .ex_rs_data(s_rs_data),
    .ex_rt_data(s_rt_data), .ex_imm(s_imm), .ex_shamt(s_shamt),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_wreg(s_wreg), .ex_valid(s_valid),
    .stall_id(s_stall), .bubble_cnt(s_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand values are derived from the register numbers so captures are traceable.
  task automatic apply_stimulus(input logic [CTRL_W-1:0] ctrl, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic uses_rt);
    id_ctrl     = ctrl;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_uses_rt  = uses_rt;
    id_pc_plus4 = 32'h0040_0000 | {22'd0, rs, 5'd0};
    id_rs_data  = 32'hA000_0000 | {27'd0, rs};
    id_rt_data  = 32'hB000_0000 | {27'd0, rt};
    id_imm      = 32'h0000_1000 | {27'd0, rd};
    id_shamt    = rd;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; flush = 1'b0;
    apply_stimulus(C_LW, 5'd3, 5'd4, 5'd5, 1'b1);
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b want=0", ex_valid); end
    total++; if (ex_ctrl !== '0) begin bad++; $display("[TB] FAIL reset_ctrl got=%h want=0", ex_ctrl); end
    total++; if (bubble_cnt !== '0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", bubble_cnt); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%0b want=0", stall_id); end
    total++; if (ex_rs_data !== '0) begin bad++; $display("[TB] FAIL reset_rsdata got=%h want=0", ex_rs_data); end
    reset = 1'b0;
  endtask

  task automatic test_load_use();
    apply_stimulus(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    total++; if (ex_wreg !== 5'd8) begin bad++; $display("[TB] FAIL lw_wreg got=%0d want=8", ex_wreg); end
    total++; if (ex_ctrl !== C_LW) begin bad++; $display("[TB] FAIL lw_ctrl got=%h want=%h", ex_ctrl, C_LW); end
    apply_stimulus(C_ADD, 5'd8, 5'd2, 5'd10, 1'b1);
    total++; if (stall_id !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%0b want=1", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble_valid got=%0b want=0", ex_valid); end
    total++; if (ex_ctrl !== '0) begin bad++; $display("[TB] FAIL lu_bubble_ctrl got=%h want=0", ex_ctrl); end
    total++; if (bubble_cnt !== 16'd1) begin bad++; $display("[TB] FAIL lu_cnt got=%0d want=1", bubble_cnt); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall_end got=%0b want=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_valid got=%0b want=1", ex_valid); end
    total++; if (ex_ctrl !== C_ADD) begin bad++; $display("[TB] FAIL add_ctrl got=%h want=%h", ex_ctrl, C_ADD); end
    total++; if (ex_wreg !== 5'd10) begin bad++; $display("[TB] FAIL add_wreg got=%0d want=10", ex_wreg); end
    total++; if (ex_rs_data !== 32'hA000_0008) begin bad++; $display("[TB] FAIL add_rsdata got=%h want=a0000008", ex_rs_data); end
    total++; if (ex_pc_plus4 !== 32'h0040_0100) begin bad++; $display("[TB] FAIL add_pc got=%h want=00400100", ex_pc_plus4); end
    total++; if (ex_rs !== 5'd8 || ex_rt !== 5'd2) begin bad++; $display("[TB] FAIL add_srcs got=%0d/%0d want=8/2", ex_rs, ex_rt); end
  endtask

  task automatic test_hazard_cases();
    apply_stimulus(C_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    apply_stimulus(C_ADD, 5'd0, 5'd0, 5'd11, 1'b1);
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL zero_reg_stall got=%0b want=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_wreg !== 5'd11) begin bad++; $display("[TB] FAIL zero_reg_capture got=%0b/%0d want=1/11", ex_valid, ex_wreg); end
    apply_stimulus(C_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    tick();
    apply_stimulus(C_SW, 5'd3, 5'd9, 5'd0, 1'b1);
    total++; if (stall_id !== 1'b1) begin bad++; $display("[TB] FAIL sw_rt_stall got=%0b want=1", stall_id); end
    apply_stimulus(C_SW, 5'd3, 5'd9, 5'd0, 1'b0);
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL no_rt_stall got=%0b want=0", stall_id); end
    tick();
    total++; if (ex_ctrl !== C_SW || ex_valid !== 1'b1) begin bad++; $display("[TB] FAIL sw_capture got=%h/%0b want=%h/1", ex_ctrl, ex_valid, C_SW); end
    total++; if (bubble_cnt !== 16'd1) begin bad++; $display("[TB] FAIL cases_cnt got=%0d want=1", bubble_cnt); end
  endtask

  task automatic test_flush();
    apply_stimulus(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    flush = 1'b1;
    apply_stimulus(C_ADD, 5'd8, 5'd2, 5'd12, 1'b1);
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall got=%0b want=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin bad++; $display("[TB] FAIL flush_bubble got=%0b/%h want=0/0", ex_valid, ex_ctrl); end
    total++; if (bubble_cnt !== 16'd1) begin bad++; $display("[TB] FAIL flush_cnt got=%0d want=1", bubble_cnt); end
    flush = 1'b0;
  endtask

  task automatic test_hold_flush();
    apply_stimulus(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    hold = 1'b1; flush = 1'b1;
    apply_stimulus(C_ADD, 5'd8, 5'd2, 5'd13, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++; if (stall_id !== 1'b1) begin bad++; $display("[TB] FAIL hold_stall[%0d] got=%0b want=1", i, stall_id); end
      tick();
      total++; if (ex_valid !== 1'b1 || ex_ctrl !== C_LW || ex_wreg !== 5'd8) begin
        bad++; $display("[TB] FAIL hold_frozen[%0d] got=%0b/%h/%0d want=1/%h/8", i, ex_valid, ex_ctrl, ex_wreg, C_LW);
      end
    end
    hold = 1'b0;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL hold_drop_stall got=%0b want=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b0 || ex_ctrl !== '0) begin bad++; $display("[TB] FAIL hold_drop_bubble got=%0b/%h want=0/0", ex_valid, ex_ctrl); end
    total++; if (bubble_cnt !== 16'd1) begin bad++; $display("[TB] FAIL hold_cnt got=%0d want=1", bubble_cnt); end
    flush = 1'b0;
  endtask

  task automatic test_regdst();
    apply_stimulus(C_JAL, 5'd4, 5'd6, 5'd5, 1'b0);
    tick();
    total++; if (ex_wreg !== 5'd31) begin bad++; $display("[TB] FAIL regdst_ra got=%0d want=31", ex_wreg); end
    apply_stimulus(C_XP, 5'd4, 5'd6, 5'd5, 1'b0);
    tick();
    total++; if (ex_wreg !== 5'd26) begin bad++; $display("[TB] FAIL regdst_xp got=%0d want=26", ex_wreg); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
      tick();
      apply_stimulus(C_ADD, 5'd8, 5'd2, 5'd14, 1'b1);
      tick();
      tick();
    end
    total++; if (bubble_cnt !== 16'd5) begin bad++; $display("[TB] FAIL sat_wide_cnt got=%0d want=5", bubble_cnt); end
    total++; if (s_cnt !== 2'd3) begin bad++; $display("[TB] FAIL sat_narrow_cnt got=%0d want=3", s_cnt); end
    total++; if (s_valid !== 1'b1 || s_wreg !== 5'd14) begin bad++; $display("[TB] FAIL sat_narrow_capture got=%0b/%0d want=1/14", s_valid, s_wreg); end
  endtask

  task automatic test_reset_mid_stall();
    apply_stimulus(C_LW, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    apply_stimulus(C_ADD, 5'd8, 5'd2, 5'd15, 1'b1);
    total++; if (stall_id !== 1'b1) begin bad++; $display("[TB] FAIL mid_stall_pre got=%0b want=1", stall_id); end
    reset = 1'b1; hold = 1'b1;
    tick();
    total++; if (ex_valid !== 1'b0 || bubble_cnt !== '0) begin bad++; $display("[TB] FAIL mid_reset_state got=%0b/%0d want=0/0", ex_valid, bubble_cnt); end
    total++; if (stall_id !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset_hold_stall got=%0b want=1", stall_id); end
    hold = 1'b0;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_stall got=%0b want=0", stall_id); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_hazard_cases();
    test_flush();
    test_hold_flush();
    test_regdst();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
